branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
// PURPOSE
//  Consumes the resolved branch outcome of the execute-stage ALU and predicts branches at fetch.
//  Holds a direct-mapped table of 2-bit saturating counters plus a tagged BTB.
//  Fetch reads a prediction in the same cycle. Execute reports the resolved outcome.
//  The block then raises a registered mispredict/redirect that the PC mux and flush logic use.
// PARAMETERS
//  INDEX_BITS  6   table depth = 2**INDEX_BITS entries; index = pc[INDEX_BITS+1:2]
//  TAG_BITS    30-INDEX_BITS (derived localparam)   tag = pc[31:INDEX_BITS+2]
// PORTS
//  clk             in   1   system clock, rising edge
//  rst             in   1   synchronous, active-high reset
//  if_pc           in   32  fetch PC
//  if_valid        in   1   fetch PC valid; when low, pred_taken=0
//  pred_taken      out  1   predict taken (combinational from if_pc)
//  pred_target     out  32  predicted next PC (combinational)
//  ex_valid        in   1   execute-stage instruction valid
//  ex_is_branch    in   1   instruction is a conditional branch (alu_op[3:2]==2'b11)
//  ex_pc           in   32  PC of execute-stage instruction
//  ex_taken        in   1   ALU branch output
//  ex_target       in   32  computed branch target
//  ex_pred_taken   in   1   pred_taken carried down the pipe with this instruction
//  ex_pred_target  in   32  pred_target carried down the pipe
//  mispredict      out  1   registered; one-cycle pulse, flush younger stages
//  redirect_pc     out  32  registered; correct next PC, valid while mispredict=1
//  branch_count    out  32  resolved-branch counter, wraps at 2**32
//  mispred_count   out  32  mispredict counter, wraps at 2**32
// BEHAVIOUR
//  Reset (sync): all counters=2'b01 (weak NT); all BTB valid=0.
//   Also at reset: mispredict=0, redirect_pc=0, branch_count=0, mispred_count=0.
//  Predict (comb):
//   hit = if_valid & btb_valid[idx] & btb_tag[idx]==tag(if_pc).
//   pred_taken = hit & ctr[idx][1].
//   pred_target = pred_taken ? btb_target[idx] : if_pc+4 (mod 2**32).
//  Table reads return pre-edge state. No same-cycle bypass from a concurrent resolve.
//  Resolve (at edge, when ex_valid & ex_is_branch):
//   - ctr[eidx]: taken -> sat. increment (max 2'b11); not taken -> sat. decrement (min 2'b00).
//   - ex_taken=1: BTB[eidx] <= {valid=1, tag(ex_pc), ex_target}, replacing any alias.
//   - ex_taken=0: BTB left unchanged.
//   - branch_count += 1.
//  Mispredict conditions (evaluated at edge, when ex_valid):
//   a) is_branch & (ex_taken != ex_pred_taken)
//   b) is_branch & ex_taken & ex_pred_taken & (ex_target != ex_pred_target)
//   c) ~is_branch & ex_pred_taken (BTB alias hit on a non-branch)
//  On any of a/b/c, the next cycle has:
//   mispredict=1; mispred_count+=1.
//   redirect_pc = (is_branch & ex_taken) ? ex_target : ex_pc+4.
//  Case c also clears btb_valid[eidx] if the tag matches; the counter is untouched.
//  Otherwise mispredict=0 next cycle. redirect_pc holds its last value.
//  ex_valid=0: no table, counter or stat update; mispredict=0 next cycle.
//  Same-index fetch read and resolve write in one cycle: read returns old entry.
//  rst asserted mid-operation overrides every pending update on that edge.
//  A pending mispredict pulse is dropped.
//  Counters wrap silently; no overflow flag.
// TESTING
//  1. After rst, if_pc=0x100, if_valid=1 -> pred_taken=0, pred_target=0x104.
//  2. Resolve taken branch pc=0x100, target 0x80, pred_taken=0:
//     next cycle mispredict=1, redirect_pc=0x80, mispred_count=1.
//     Counter is then 2'b10, so if_pc=0x100 -> pred_taken=1, pred_target=0x80.
//  3. Resolve the same branch taken 3 more times, then not taken once:
//     counter stays 2'b10 (saturated at 11, then decremented); prediction still taken.
//  4. Resolve pc=0x100 predicted taken->0x80, actual taken->0x90:
//     mispredict=1, redirect_pc=0x90; BTB target becomes 0x90.
//  5. Non-branch at a PC aliasing a BTB entry with matching tag, ex_pred_taken=1:
//     mispredict=1, redirect_pc=ex_pc+4, entry invalidated, branch_count unchanged.
//  6. Assert rst in the cycle after a mispredicting resolve:
//     mispredict=0, all stats=0, all lookups predict not taken.
//     Also cover branch_count wrap 0xFFFFFFFF -> 0.

Source files
------------

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - 2-bit counter table plus tagged BTB with registered mispredict/redirect
module branch_predictor #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  input  logic        if_valid,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] branch_count,
  output logic [31:0] mispred_count
);

  localparam int TAG_BITS = 30 - INDEX_BITS;
  localparam int DEPTH    = 1 << INDEX_BITS;

  logic [1:0]          ctr        [DEPTH];
  logic [DEPTH-1:0]    btb_valid;
  logic [TAG_BITS-1:0] btb_tag    [DEPTH];
  logic [31:0]         btb_target [DEPTH];

  logic [INDEX_BITS-1:0] if_idx, ex_idx;
  logic [TAG_BITS-1:0]   if_tag, ex_tag;
  logic                  hit;

  assign if_idx = if_pc[INDEX_BITS+1:2];
  assign if_tag = if_pc[31:INDEX_BITS+2];
  assign ex_idx = ex_pc[INDEX_BITS+1:2];
  assign ex_tag = ex_pc[31:INDEX_BITS+2];

  // Fetch sees pre-edge table contents; a concurrent resolve is not bypassed.
  assign hit         = if_valid & btb_valid[if_idx] & (btb_tag[if_idx] == if_tag);
  assign pred_taken  = hit & ctr[if_idx][1];
  assign pred_target = pred_taken ? btb_target[if_idx] : if_pc + 32'd4;

  logic        resolve;
  logic        mis_dir, mis_tgt, mis_alias, mis_any;
  logic        alias_clear;
  logic [31:0] redirect_next;
  logic [1:0]  ctr_next;

  assign resolve     = ex_valid & ex_is_branch;
  assign mis_dir     = resolve & (ex_taken != ex_pred_taken);
  assign mis_tgt     = resolve & ex_taken & ex_pred_taken & (ex_target != ex_pred_target);
  assign mis_alias   = ex_valid & ~ex_is_branch & ex_pred_taken;
  assign mis_any     = mis_dir | mis_tgt | mis_alias;
  // Only drop the entry that actually produced the bogus hit.
  assign alias_clear = mis_alias & (btb_tag[ex_idx] == ex_tag);
  assign redirect_next = (ex_is_branch & ex_taken) ? ex_target : ex_pc + 32'd4;

  always_comb begin
    ctr_next = ctr[ex_idx];
    if (ex_taken) begin
      if (ctr[ex_idx] != 2'b11) ctr_next = ctr[ex_idx] + 2'b01;
    end else begin
      if (ctr[ex_idx] != 2'b00) ctr_next = ctr[ex_idx] - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctr[i] <= 2'b01;
      end
      btb_valid <= '0;
    end else begin
      if (resolve) begin
        ctr[ex_idx] <= ctr_next;
        if (ex_taken) begin
          btb_valid[ex_idx]  <= 1'b1;
          btb_tag[ex_idx]    <= ex_tag;
          btb_target[ex_idx] <= ex_target;
        end
      end
      if (alias_clear) btb_valid[ex_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mispredict    <= 1'b0;
      redirect_pc   <= 32'd0;
      branch_count  <= 32'd0;
      mispred_count <= 32'd0;
    end else begin
      mispredict <= mis_any;
      if (mis_any) begin
        redirect_pc   <= redirect_next;
        mispred_count <= mispred_count + 32'd1;
      end
      if (resolve) branch_count <= branch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - scoreboard bench for branch_predictor
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] if_pc = 32'd0;
  logic        if_valid = 1'b0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid = 1'b0;
  logic        ex_is_branch = 1'b0;
  logic [31:0] ex_pc = 32'd0;
  logic        ex_taken = 1'b0;
  logic [31:0] ex_target = 32'd0;
  logic        ex_pred_taken = 1'b0;
  logic [31:0] ex_pred_target = 32'd0;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] branch_count;
  logic [31:0] mispred_count;

  branch_predictor dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_valid(if_valid),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc),
    .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .branch_count(branch_count), .mispred_count(mispred_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        mis;
    logic [31:0] redir;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t sb_q[$];

  logic [1:0]  m_ctr   [64];
  logic        m_valid [64];
  logic [23:0] m_tag   [64];
  logic [31:0] m_tgt   [64];
  logic        m_mis;
  logic [31:0] m_redir, m_bc, m_mc;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] model_pred(input logic [31:0] pc, input logic v);
    logic [5:0] idx;
    logic       tk;
    idx = pc[7:2];
    tk  = v && m_valid[idx] && (m_tag[idx] == pc[31:8]) && m_ctr[idx][1];
    return {tk, tk ? m_tgt[idx] : pc + 32'd4};
  endfunction

  task automatic check_pred(input logic [31:0] pc, input logic v);
    logic [32:0] e;
    if_pc = pc;
    if_valid = v;
    #1;
    e = model_pred(pc, v);
    check_val("pred_taken", {31'd0, pred_taken}, {31'd0, e[32]});
    check_val("pred_target", pred_target, e[31:0]);
  endtask

  task automatic model_step(input logic r, input logic v, input logic br, input logic [31:0] pc,
                            input logic tk, input logic [31:0] tg, input logic pt,
                            input logic [31:0] ptg);
    logic [5:0] idx;
    logic       mis;
    exp_t       e;
    idx = pc[7:2];
    if (r) begin
      for (int i = 0; i < 64; i++) begin
        m_ctr[i] = 2'b01;
        m_valid[i] = 1'b0;
      end
      m_mis = 1'b0; m_redir = 32'd0; m_bc = 32'd0; m_mc = 32'd0;
    end else begin
      mis = 1'b0;
      if (v && br) begin
        mis = (tk != pt) || (tk && pt && (tg != ptg));
        if (tk && m_ctr[idx] < 2'b11) m_ctr[idx] = m_ctr[idx] + 2'b01;
        if (!tk && m_ctr[idx] > 2'b00) m_ctr[idx] = m_ctr[idx] - 2'b01;
        if (tk) begin
          m_valid[idx] = 1'b1;
          m_tag[idx] = pc[31:8];
          m_tgt[idx] = tg;
        end
        m_bc = m_bc + 32'd1;
      end else if (v && pt) begin
        mis = 1'b1;
        if (m_tag[idx] == pc[31:8]) m_valid[idx] = 1'b0;
      end
      if (mis) begin
        m_mc = m_mc + 32'd1;
        m_redir = (br && tk) ? tg : pc + 32'd4;
      end
      m_mis = mis;
    end
    e.mis = m_mis; e.redir = m_redir; e.bc = m_bc; e.mc = m_mc;
    sb_q.push_back(e);
  endtask

  // One clock: drive, check same-cycle lookup against old state, then score registered outputs.
  task automatic drive_cycle(input logic r, input logic v, input logic br, input logic [31:0] pc,
                             input logic tk, input logic [31:0] tg, input logic pt,
                             input logic [31:0] ptg);
    exp_t e;
    rst = r; ex_valid = v; ex_is_branch = br; ex_pc = pc;
    ex_taken = tk; ex_target = tg; ex_pred_taken = pt; ex_pred_target = ptg;
    if (!r) check_pred(pc, 1'b1);
    model_step(r, v, br, pc, tk, tg, pt, ptg);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ex_valid = 1'b0;
    if (sb_q.size() == 0) begin
      check_val("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check_val("mispredict", {31'd0, mispredict}, {31'd0, e.mis});
      check_val("redirect_pc", redirect_pc, e.redir);
      check_val("branch_count", branch_count, e.bc);
      check_val("mispred_count", mispred_count, e.mc);
    end
  endtask

  initial begin
    logic [31:0] pcs [4];
    pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h1100; pcs[3] = 32'h200;

    drive_cycle(1, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    check_val("reset_mispredict", {31'd0, mispredict}, 32'd0);
    check_val("reset_branch_count", branch_count, 32'd0);

    check_pred(32'h100, 1'b1);
    check_val("t1_pred_taken", {31'd0, pred_taken}, 32'd0);
    check_val("t1_pred_target", pred_target, 32'h104);
    check_pred(32'h100, 1'b0);

    drive_cycle(0, 1, 1, 32'h100, 1, 32'h80, 0, 32'h104);
    check_val("t2_mispredict", {31'd0, mispredict}, 32'd1);
    check_val("t2_redirect", redirect_pc, 32'h80);
    check_val("t2_mispred_count", mispred_count, 32'd1);
    check_pred(32'h100, 1'b1);
    check_val("t2_pred_target", pred_target, 32'h80);

    for (int i = 0; i < 3; i++) drive_cycle(0, 1, 1, 32'h100, 1, 32'h80, 1, 32'h80);
    drive_cycle(0, 1, 1, 32'h100, 0, 32'h80, 1, 32'h80);
    check_val("t3_redirect", redirect_pc, 32'h104);
    check_pred(32'h100, 1'b1);
    check_val("t3_pred_taken", {31'd0, pred_taken}, 32'd1);

    drive_cycle(0, 1, 1, 32'h100, 1, 32'h90, 1, 32'h80);
    check_val("t4_redirect", redirect_pc, 32'h90);
    check_pred(32'h100, 1'b1);
    check_val("t4_pred_target", pred_target, 32'h90);

    drive_cycle(0, 0, 0, 32'h100, 0, 32'h0, 0, 32'h0);
    drive_cycle(0, 1, 0, 32'h100, 0, 32'h0, 1, 32'h90);
    check_val("t5_redirect", redirect_pc, 32'h104);
    check_pred(32'h100, 1'b1);
    check_val("t5_invalidated", {31'd0, pred_taken}, 32'd0);

    drive_cycle(0, 1, 1, 32'h104, 1, 32'h200, 0, 32'h108);
    drive_cycle(0, 1, 0, 32'h1104, 0, 32'h0, 1, 32'h200);
    check_pred(32'h104, 1'b1);
    check_val("alias_tag_miss_kept", pred_target, 32'h200);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] p;
      p = pcs[$urandom_range(0, 3)];
      drive_cycle(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), p,
                  1'($urandom_range(0, 1)), {24'd0, 8'($urandom_range(0, 3)) << 4},
                  1'($urandom_range(0, 1)), {24'd0, 8'($urandom_range(0, 3)) << 4});
    end

    drive_cycle(0, 1, 1, 32'h200, 1, 32'h40, 0, 32'h204);
    drive_cycle(1, 1, 1, 32'h200, 1, 32'h50, 0, 32'h204);
    check_val("t6_mispredict", {31'd0, mispredict}, 32'd0);
    check_val("t6_mispred_count", mispred_count, 32'd0);
    foreach (pcs[i]) check_pred(pcs[i], 1'b1);
    check_pred(32'h200, 1'b1);
    check_val("t6_pred_taken", {31'd0, pred_taken}, 32'd0);

    force dut.branch_count = 32'hFFFF_FFFF;
    #1;
    release dut.branch_count;
    m_bc = 32'hFFFF_FFFF;
    drive_cycle(0, 1, 1, 32'h300, 0, 32'h0, 0, 32'h0);
    check_val("wrap_branch_count", branch_count, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
